// File: rtl/traffic_monitor.sv
// Passive checker for a three-lamp traffic light. It tracks the lamp phase and flags
// illegal lamp patterns, illegal sequences and wrong dwell lengths.
module traffic_monitor #(
    parameter int RED_LEN    = 8,
    parameter int YELLOW_LEN = 6,
    parameter int GREEN_LEN  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       on,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       clear_err,
    output logic [2:0] obs_state,
    output logic       err_lamp,
    output logic       err_seq,
    output logic       err_time,
    output logic [2:0] err_sticky,
    output logic [7:0] cycle_cnt
);
    typedef enum logic [2:0] {
        S_OFF    = 3'b000,
        S_RED    = 3'b001,
        S_YELLOW = 3'b010,
        S_GREEN  = 3'b100,
        S_RESYNC = 3'b111
    } state_t;

    localparam logic [7:0] RED_L    = 8'(RED_LEN);
    localparam logic [7:0] YELLOW_L = 8'(YELLOW_LEN);
    localparam logic [7:0] GREEN_L  = 8'(GREEN_LEN);

    state_t     state, n_state, lamp_st;
    logic       on_d;
    logic [7:0] dwell, n_dwell, n_cnt, cur_len;
    logic [2:0] lamps;
    logic       one_hot, legal, allowed;
    logic       p_lamp, p_seq, p_time;

    assign lamps     = {green, yellow, red};
    assign lamp_st   = state_t'(lamps);
    assign one_hot   = (lamps == 3'b001) || (lamps == 3'b010) || (lamps == 3'b100);
    assign legal     = on_d ? one_hot : (lamps == 3'b000);
    assign obs_state = state;

    always_comb begin
        case (state)
            S_RED:    cur_len = RED_L;
            S_YELLOW: cur_len = YELLOW_L;
            S_GREEN:  cur_len = GREEN_L;
            default:  cur_len = 8'd0;
        endcase
    end

    // Error priority: lamp pattern first, then sequence, then timing.
    always_comb begin
        n_state = state;
        n_dwell = dwell;
        n_cnt   = cycle_cnt;
        p_lamp  = 1'b0;
        p_seq   = 1'b0;
        p_time  = 1'b0;
        allowed = 1'b0;
        if (!legal) begin
            p_lamp  = 1'b1;
            n_state = S_RESYNC;
            n_dwell = 8'd0;
        end else if (lamps == 3'b000) begin
            n_state = S_OFF;
            n_dwell = 8'd0;
        end else if (lamp_st == state) begin
            if (dwell != 8'hff)
                n_dwell = dwell + 8'd1;
            // Fires once: dwell moves past LEN on this sample and never returns to it.
            if (dwell == cur_len)
                p_time = 1'b1;
        end else begin
            n_state = lamp_st;
            n_dwell = 8'd1;
            allowed = (state == S_RESYNC) ||
                      (state == S_OFF    && lamp_st == S_RED)    ||
                      (state == S_RED    && lamp_st == S_YELLOW) ||
                      (state == S_YELLOW && lamp_st == S_GREEN)  ||
                      (state == S_GREEN  && lamp_st == S_RED);
            if (!allowed)
                p_seq = 1'b1;
            else if (state != S_OFF && state != S_RESYNC && dwell < cur_len)
                p_time = 1'b1;
            if (allowed && state == S_GREEN)
                n_cnt = cycle_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_OFF;
            dwell      <= 8'd0;
            on_d       <= 1'b0;
            err_lamp   <= 1'b0;
            err_seq    <= 1'b0;
            err_time   <= 1'b0;
            err_sticky <= 3'b000;
            cycle_cnt  <= 8'd0;
        end else begin
            state      <= n_state;
            dwell      <= n_dwell;
            on_d       <= on;
            err_lamp   <= p_lamp;
            err_seq    <= p_seq;
            err_time   <= p_time;
            cycle_cnt  <= n_cnt;
            err_sticky <= (clear_err ? 3'b000 : err_sticky) | {p_time, p_seq, p_lamp};
        end
    end
endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: legal cycling, timing/sequence/lamp errors,
// sticky clearing, on-drop, reset and cycle counter wrap.
module tb_traffic_monitor;
    logic       clk = 1'b0;
    logic       reset, on, red, yellow, green, clear_err;
    logic [2:0] obs_state, err_sticky;
    logic       err_lamp, err_seq, err_time;
    logic [7:0] cycle_cnt;
    logic [2:0] acc;
    int         total = 0;
    int         bad = 0;

    localparam logic [2:0] DK = 3'b000, R = 3'b001, Y = 3'b010, G = 3'b100;

    traffic_monitor dut (
        .clk(clk), .reset(reset), .on(on), .red(red), .yellow(yellow), .green(green),
        .clear_err(clear_err), .obs_state(obs_state), .err_lamp(err_lamp),
        .err_seq(err_seq), .err_time(err_time), .err_sticky(err_sticky),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] pulses();
        return {err_time, err_seq, err_lamp};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] l);
        {green, yellow, red} = l;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [2:0] l, input int n);
        repeat (n) begin
            step(l);
            acc |= pulses();
        end
    endtask

    initial begin
        reset = 1'b1; on = 1'b0; clear_err = 1'b0; acc = '0;
        step(DK); step(DK);
        chk("rst_obs", 8'(obs_state), 8'h0);
        chk("rst_pulses", 8'(pulses()), 8'h0);
        chk("rst_sticky", 8'(err_sticky), 8'h0);
        chk("rst_cnt", cycle_cnt, 8'd0);

        // three clean R8/Y6/G8 cycles
        reset = 1'b0; on = 1'b1;
        step(DK);
        chk("first_dark", {2'b0, obs_state, pulses()}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            hold(R, 8); chk("clean_red", 8'(obs_state), 8'(R));
            hold(Y, 6); chk("clean_yel", 8'(obs_state), 8'(Y));
            hold(G, 8); chk("clean_grn", 8'(obs_state), 8'(G));
        end
        step(R);
        chk("clean_acc", 8'(acc), 8'h0);
        chk("clean_cnt", cycle_cnt, 8'd3);

        // short red, then long red
        acc = '0;
        hold(R, 6);
        step(Y);
        chk("short_pulse", 8'(pulses()), 8'(3'b100));
        chk("short_sticky", 8'(err_sticky), 8'(3'b100));
        step(Y);
        chk("short_once", 8'(pulses()), 8'h0);
        hold(Y, 4); hold(G, 8); step(R);
        chk("cnt4", cycle_cnt, 8'd4);
        hold(R, 7);
        chk("long_pre", 8'(acc), 8'h0);
        step(R);
        chk("long_9th", 8'(pulses()), 8'(3'b100));
        step(R);
        chk("long_10th", 8'(pulses()), 8'h0);
        step(Y);
        chk("long_exit", 8'(pulses()), 8'h0);

        // red -> green sequence error; green then timed from 1
        acc = '0;
        hold(Y, 5); hold(G, 8); hold(R, 8);
        chk("pre_seq_acc", 8'(acc), 8'h0);
        step(G);
        chk("seq_pulse", 8'(pulses()), 8'(3'b010));
        chk("seq_obs", 8'(obs_state), 8'(G));
        hold(G, 7); step(R);
        chk("seq_dwell", 8'(pulses()), 8'h0);
        chk("cnt6", cycle_cnt, 8'd6);

        // two lamps lit, then resync to yellow
        step(R | G);
        chk("lamp_pulse", 8'(pulses()), 8'(3'b001));
        chk("lamp_obs", 8'(obs_state), 8'(3'b111));
        step(Y);
        chk("resync_obs", 8'(obs_state), 8'(Y));
        chk("resync_pulse", 8'(pulses()), 8'h0);
        chk("sticky_all", 8'(err_sticky), 8'(3'b111));

        // clear coinciding with a new seq error
        clear_err = 1'b1;
        step(R);
        chk("clr_seq", 8'(err_sticky), 8'(3'b010));
        step(R);
        chk("clr_done", 8'(err_sticky), 8'h0);
        clear_err = 1'b0;

        // on dropped mid-green
        acc = '0;
        hold(R, 6); hold(Y, 6); hold(G, 4);
        on = 1'b0;
        step(G); acc |= pulses();
        step(DK); acc |= pulses();
        chk("drop_obs", 8'(obs_state), 8'h0);
        chk("drop_acc", 8'(acc), 8'h0);
        on = 1'b1;
        step(DK); step(R); step(R);
        on = 1'b0;
        step(R);
        chk("drop_lit1", 8'(pulses()), 8'h0);
        step(R);
        chk("drop_lit2", 8'(pulses()), 8'(3'b001));

        // reset mid-red
        on = 1'b1;
        step(DK); step(R); step(R);
        reset = 1'b1;
        step(R);
        chk("mid_rst_obs", 8'(obs_state), 8'h0);
        chk("mid_rst_pulses", 8'(pulses()), 8'h0);
        chk("mid_rst_sticky", 8'(err_sticky), 8'h0);
        chk("mid_rst_cnt", cycle_cnt, 8'd0);
        reset = 1'b0;
        step(R);
        chk("post_rst_lamp", 8'(pulses()), 8'(3'b001));

        // counter wrap
        acc = '0;
        step(R);
        chk("resync_red", 8'(obs_state), 8'(R));
        hold(R, 7);
        for (int i = 0; i < 256; i++) begin
            hold(Y, 6); hold(G, 8); hold(R, 8);
            if (i == 254) chk("cnt255", cycle_cnt, 8'd255);
        end
        chk("cnt_wrap", cycle_cnt, 8'd0);
        chk("wrap_acc", 8'(acc), 8'h0);
        chk("wrap_sticky", 8'(err_sticky), 8'(3'b001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/traffic_monitor.md
TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 Parameter RED_LEN, default 8, required RED dwell in cycles (legal range 1..254).
REQ-002 Parameter YELLOW_LEN, default 6, required YELLOW dwell in cycles (legal range 1..254).
REQ-003 Parameter GREEN_LEN, default 8, required GREEN dwell in cycles (legal range 1..254).
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 on  in  1  enable seen by the light controller.
REQ-007 red, yellow, green  in  1 each  lamp signals under observation.
REQ-008 clear_err  in  1  clears sticky error flags.
REQ-009 obs_state  out  3  decoded lamp state: OFF=000, RED=001, YELLOW=010, GREEN=100, RESYNC=111.
REQ-010 err_lamp, err_seq, err_time  out  1 each  single-cycle error pulses.
REQ-011 err_sticky  out  3  latched errors {time, seq, lamp}.
REQ-012 cycle_cnt  out  8  completed GREEN->RED transitions, wraps.

Function
REQ-013 Module SHALL register on as on_d each cycle; on_d is the expectation reference for the current lamp sample.
REQ-014 Lamp pattern SHALL be legal iff (on_d=0 and all lamps 0) or (on_d=1 and exactly one lamp 1).
REQ-015 Illegal pattern SHALL pulse err_lamp next cycle, set obs_state=RESYNC, clear dwell.
REQ-016 Legal all-dark sample SHALL set obs_state=OFF, clear dwell, no timing check on the aborted phase.
REQ-017 Legal lit lamp equal to obs_state SHALL increment dwell (8-bit, saturate at 255).
REQ-018 Legal lit lamp differing from obs_state SHALL set obs_state to that lamp and dwell=1.
REQ-019 Allowed transitions: OFF->RED, RED->YELLOW, YELLOW->GREEN, GREEN->RED, RESYNC->any lamp; any other lamp change SHALL pulse err_seq next cycle.
REQ-020 On an allowed RED/YELLOW/GREEN->next transition, dwell < LEN of the leaving phase SHALL pulse err_time (short phase).
REQ-021 Sample where current lamp persists with dwell already = LEN SHALL pulse err_time once (long phase); no further err_time for that phase, including at its exit.
REQ-022 OFF->RED entry SHALL not be timing-checked; the first RED phase is timed from entry.
REQ-023 Multiple violations in one sample: err_lamp suppresses err_seq/err_time; err_seq and err_time SHALL not coincide (sequence error skips timing check).
REQ-024 GREEN->RED allowed transition SHALL increment cycle_cnt, 255 wraps to 0.
REQ-025 Each error pulse SHALL set its err_sticky bit; clear_err SHALL clear all bits; a pulse coinciding with clear_err SHALL leave its bit set.
REQ-026 All outputs SHALL be registered; pulse latency exactly one cycle after the offending sample edge.

Reset
REQ-027 reset SHALL force obs_state=OFF, dwell=0, on_d=0, err pulses=0, err_sticky=000, cycle_cnt=0 on the next clock edge, overriding all inputs.
REQ-028 Reset mid-phase SHALL discard the phase; first sample after reset release judged per REQ-014 with on_d=0.

Verification
REQ-029 on=1 from cycle 0, lamps driven R8,Y6,G8 repeated 3 times -> no error pulses, cycle_cnt=3, obs_state tracks lamps.
REQ-030 RED held 7 cycles then YELLOW -> err_time pulse 1 cycle after YELLOW sample, err_sticky=100; RED held 10 cycles -> exactly one err_time at 9th RED sample.
REQ-031 RED then GREEN directly -> err_seq pulse, no err_time, obs_state=100, dwell restarts at 1.
REQ-032 red=1,green=1 together -> err_lamp, obs_state=111; next sample YELLOW -> obs_state=010, no err_seq.
REQ-033 on dropped mid-GREEN (dwell 4), lamps dark following cycle -> no errors, obs_state=000; lamps still lit 2 cycles after drop -> err_lamp.
REQ-034 err_sticky=111, clear_err=1 same cycle as new err_seq -> err_sticky=010; reset asserted mid-RED -> all outputs zero after one edge.
